// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter for a shared 4:1-muxed resource
// Holds a grant until done, request withdrawal or timeout, then inserts a one-cycle gap.
module mux4_rr_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] cnt;

  logic       found;
  logic [1:0] win;
  logic [1:0] scan;
  logic       owner_req;
  logic       at_limit;
  logic       release_now;

  // Scan starting at ptr; the first requester found wins.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    scan  = ptr;
    for (int k = 0; k < 4; k++) begin
      scan = ptr + 2'(k);
      if (!found && req[scan]) begin
        found = 1'b1;
        win   = scan;
      end
    end
  end

  assign owner_req   = req[sel];
  assign at_limit    = (cnt == CNT_LAST);
  assign release_now = done || !owner_req || at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= 4'b0000;
      sel     <= 2'b00;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= 2'b00;
      cnt     <= 8'd0;
    end else begin
      timeout <= 1'b0;
      case (state)
        GRANT: begin
          if (release_now) begin
            state   <= GAP;
            grant   <= 4'b0000;
            busy    <= 1'b0;
            ptr     <= sel + 2'd1;
            // done and a dropped request both count as normal completion
            timeout <= at_limit && !done && owner_req;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          if (found) begin
            state <= GRANT;
            grant <= 4'b0001 << win;
            sel   <= win;
            busy  <= 1'b1;
            cnt   <= 8'd0;
          end else begin
            state <= IDLE;
            grant <= 4'b0000;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-way-multiplexed resource (e.g. a memory or register-file port) between four requesters.
- Registers a one-hot grant and the matching 2-bit mux select.
- Holds the grant until the resource signals completion, the requester withdraws, or a timeout fires.
- Inserts one turnaround cycle between grants so the downstream 4:1 mux select never changes while a grant is live.

Parameters:
TIMEOUT, 16, max cycles one grant may be held without done; legal range 2..255.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  4  request lines; req[i] high = requester i wants the resource
done  input  1  resource completed current transaction (sampled only in GRANT)
grant  output  4  one-hot grant, registered; all zero when no owner
sel  output  2  mux select = index of current/last grantee, registered
busy  output  1  high while in GRANT state
timeout  output  1  one-cycle pulse when a grant is forcibly released

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, grant=0000, sel=00, busy=0, timeout=0.
  - Priority pointer ptr=0; hold counter cnt=0.
  - Takes effect immediately, including mid-grant. First edge after rst_n rises behaves as IDLE.
- States: IDLE, GRANT, GAP.
- Arbitration (evaluated in IDLE and GAP only):
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - If a winner exists, next state = GRANT, grant = onehot(winner), sel = winner, cnt = 0.
  - Otherwise IDLE (from GAP too), grant = 0000, sel unchanged.
- Latency: req seen at edge t from IDLE -> grant/sel/busy valid after edge t.
- GRANT, per cycle (idx = sel):
  - Release if done=1, OR req[idx]=0, OR cnt == TIMEOUT-1.
  - Otherwise stay and cnt increments by 1; cnt is 8 bits, never wraps because of the TIMEOUT bound.
  - On release:
    - next state = GAP, grant = 0000, busy = 0.
    - ptr = (idx+1) mod 4.
    - sel held at idx through GAP.
    - timeout = 1 for exactly that GAP cycle only if release was due to the cnt limit with done=0 and req[idx]=1.
- Priority of release causes: done beats timeout. done on the same cycle cnt reaches TIMEOUT-1 is a normal completion, timeout=0. done together with req drop is also normal completion.
- GAP: always exactly one cycle, and arbitrates as above.
  - Back-to-back grants: done at edge t -> GAP after t -> new grant after t+1.
- grant is always zero or one-hot; sel changes only on entry to GRANT.
- done in IDLE/GAP is ignored. req changes during GRANT for non-owners have no effect until next arbitration.
- A requester holding req continuously gets at most one grant per rotation when others request (fairness). Worst-case wait = 3 × (TIMEOUT+1) cycles.
- ptr is unchanged if no grant occurs.

Test Plan:
- Reset then req=0001, done after 3 GRANT cycles:
  - grant=0001/sel=00 one edge after req; busy high 3 cycles; GAP with grant=0000, sel=00.
  - ptr=1; next grant to req[0] if alone.
- req=1111 held, done pulsed once per grant:
  - grant sequence 0001, 0010, 0100, 1000, 0001; sel 0,1,2,3,0.
  - Exactly one GAP cycle between each grant; timeout never asserts.
- req=0100 held, done never (TIMEOUT=16):
  - grant=0100 for exactly 16 cycles.
  - timeout=1 for one cycle with grant=0000; regrant to 0100 next cycle.
- Grant to req[1], requester drops req[1] on cycle 2, req[3]=1:
  - Release, no timeout pulse; grant=1000/sel=11 after one GAP.
- rst_n driven low mid-GRANT (grant=0010):
  - grant=0000, busy=0, sel=00 asynchronously (before next clk edge).
  - After release, req=1111 grants 0001 first.
- done coincident with cnt=TIMEOUT-1: normal release, timeout stays 0.
